tcm_boot_loader: RTL and testbench

Boot-time controller that fills the core's TCM from a byte stream (UART or SPI receiver) instead of from a simulator backdoor. It holds the RISC-V core in reset and assembles incoming bytes into little-endian 32-bit words. It writes those words to sequential TCM addresses through a request/grant port, checks a length header and an additive checksum, and releases the core only after a clean load. Sits in mpei_rv_core_wrp between the peripheral receive path and the TCM write port, ahead of the core reset input.

---
 rtl/tcm_boot_pkg.sv | 26 ++
 rtl/tcm_boot_loader_byte_word_asm.sv | 53 +++++
 rtl/tcm_boot_loader.sv | 182 ++++++++++++++++++
 tb/tb_tcm_boot_loader.sv | 269 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/tcm_boot_pkg.sv
// Shared types for the TCM boot loader.
//   state_e    : loader FSM states
//   err_code_e : sticky error code reported on err_code_o
//   HDR_BYTES  : bytes per little-endian field (length, data word, checksum)
package tcm_boot_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LEN,
    ST_DATA,
    ST_WR,
    ST_CSUM,
    ST_DONE,
    ST_ERR
  } state_e;

  typedef enum logic [1:0] {
    ERR_NONE = 2'd0,
    ERR_LEN  = 2'd1,
    ERR_CSUM = 2'd2,
    ERR_TMO  = 2'd3
  } err_code_e;

  localparam int HDR_BYTES = 4;

endpackage

// File: rtl/tcm_boot_loader_byte_word_asm.sv
// Little-endian byte-to-word assembler shared by the length, data and
// checksum fields.
//   clk_i, rst_i : clock, synchronous active-high reset
//   clr_i        : restart field alignment (new load)
//   byte_en_i    : a byte is accepted this cycle
//   byte_i       : the accepted byte
//   word_o       : assembled word, meaningful while word_vld_o is high
//   word_vld_o   : pulse in the cycle the last byte of a field is accepted
module byte_word_asm
  import tcm_boot_pkg::*;
(
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        clr_i,
  input  logic        byte_en_i,
  input  logic [7:0]  byte_i,
  output logic [31:0] word_o,
  output logic        word_vld_o
);

  localparam logic [1:0] LAST_IDX = 2'(HDR_BYTES - 1);

  logic [1:0]  idx_q, idx_d;
  // Only the first three bytes need storage; the fourth is taken straight
  // from byte_i so the word is usable in the cycle it completes.
  logic [23:0] shift_q, shift_d;

  always_comb begin
    idx_d   = idx_q;
    shift_d = shift_q;
    if (clr_i) begin
      idx_d   = '0;
      shift_d = '0;
    end else if (byte_en_i) begin
      shift_d = {byte_i, shift_q[23:8]};
      idx_d   = (idx_q == LAST_IDX) ? 2'd0 : idx_q + 2'd1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      idx_q   <= '0;
      shift_q <= '0;
    end else begin
      idx_q   <= idx_d;
      shift_q <= shift_d;
    end
  end

  assign word_o     = {byte_i, shift_q};
  assign word_vld_o = byte_en_i && !clr_i && (idx_q == LAST_IDX);

endmodule

// File: rtl/tcm_boot_loader.sv
// Boot loader: holds the core in reset, receives a length-prefixed,
// checksummed little-endian word stream and writes it into the TCM.
//   clk_i, rst_i           : clock, synchronous active-high reset
//   start_i                : begin a load (honoured in IDLE/DONE/ERR)
//   byte_vld_i/byte_i/byte_rdy_o : byte stream handshake
//   mem_req_o/addr/wdata/be, mem_gnt_i : TCM write port
//   busy_o, done_o, err_o, err_code_o : load status
//   core_rst_o             : core reset, released only after a clean load
//   words_o                : words written in the current load
module tcm_boot_loader
  import tcm_boot_pkg::*;
#(
  parameter int ADDR_W      = 14,
  parameter int BASE_ADDR   = 0,
  parameter int TIMEOUT_CYC = 1000000,
  parameter int TO_W        = 20
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              start_i,
  input  logic              byte_vld_i,
  input  logic [7:0]        byte_i,
  output logic              byte_rdy_o,
  output logic              mem_req_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic [31:0]       mem_wdata_o,
  output logic [3:0]        mem_be_o,
  input  logic              mem_gnt_i,
  output logic              busy_o,
  output logic              done_o,
  output logic              err_o,
  output logic [1:0]        err_code_o,
  output logic              core_rst_o,
  output logic [ADDR_W:0]   words_o
);

  localparam logic [32:0]       MAX_WORDS = (33'd1 << ADDR_W) - 33'(BASE_ADDR);
  localparam logic [TO_W-1:0]   TMO_LAST  = TO_W'(TIMEOUT_CYC - 1);
  localparam logic [ADDR_W-1:0] BASE      = ADDR_W'(BASE_ADDR);

  state_e            state_q, state_d;
  err_code_e         err_q, err_d;
  logic [31:0]       len_q, len_d;
  logic [31:0]       sum_q, sum_d;
  logic [31:0]       wdata_q, wdata_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [ADDR_W:0]   words_q, words_d;
  logic [TO_W-1:0]   timer_q, timer_d;

  logic        rx_state;
  logic        byte_acc;
  logic        start_ok;
  logic [31:0] asm_word;
  logic        asm_vld;

  assign rx_state = (state_q == ST_LEN) || (state_q == ST_DATA) || (state_q == ST_CSUM);
  assign byte_acc = byte_vld_i && rx_state;
  assign start_ok = start_i &&
                    ((state_q == ST_IDLE) || (state_q == ST_DONE) || (state_q == ST_ERR));

  byte_word_asm u_asm (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .clr_i      (start_ok),
    .byte_en_i  (byte_acc),
    .byte_i     (byte_i),
    .word_o     (asm_word),
    .word_vld_o (asm_vld)
  );

  // State and datapath registers
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= ST_IDLE;
      err_q   <= ERR_NONE;
      len_q   <= '0;
      sum_q   <= '0;
      wdata_q <= '0;
      addr_q  <= BASE;
      words_q <= '0;
      timer_q <= '0;
    end else begin
      state_q <= state_d;
      err_q   <= err_d;
      len_q   <= len_d;
      sum_q   <= sum_d;
      wdata_q <= wdata_d;
      addr_q  <= addr_d;
      words_q <= words_d;
      timer_q <= timer_d;
    end
  end

  // Next-state and datapath update
  always_comb begin
    state_d = state_q;
    err_d   = err_q;
    len_d   = len_q;
    sum_d   = sum_q;
    wdata_d = wdata_q;
    addr_d  = addr_q;
    words_d = words_q;
    timer_d = timer_q;

    unique case (state_q)
      ST_IDLE, ST_DONE, ST_ERR: begin
        if (start_i) begin
          state_d = ST_LEN;
          err_d   = ERR_NONE;
          len_d   = '0;
          sum_d   = '0;
          addr_d  = BASE;
          words_d = '0;
          timer_d = '0;
        end
      end

      ST_LEN, ST_DATA, ST_CSUM: begin
        if (byte_acc) begin
          timer_d = '0;
        end else if (timer_q == TMO_LAST) begin
          state_d = ST_ERR;
          err_d   = ERR_TMO;
        end else begin
          timer_d = timer_q + 1'b1;
        end

        if (asm_vld) begin
          if (state_q == ST_LEN) begin
            len_d = asm_word;
            if ({1'b0, asm_word} > MAX_WORDS) begin
              state_d = ST_ERR;
              err_d   = ERR_LEN;
            end else if (asm_word == 32'd0) begin
              state_d = ST_CSUM;
            end else begin
              state_d = ST_DATA;
            end
          end else if (state_q == ST_DATA) begin
            wdata_d = asm_word;
            state_d = ST_WR;
          end else begin
            if (asm_word == sum_q) begin
              state_d = ST_DONE;
            end else begin
              state_d = ST_ERR;
              err_d   = ERR_CSUM;
            end
          end
        end
      end

      ST_WR: begin
        // Timer is deliberately untouched here: TCM stalls never time out.
        if (mem_gnt_i) begin
          sum_d   = sum_q + wdata_q;
          words_d = words_q + 1'b1;
          addr_d  = addr_q + 1'b1;
          state_d = ((32'(words_q) + 32'd1) == len_q) ? ST_CSUM : ST_DATA;
        end
      end

      default: state_d = ST_IDLE;
    endcase
  end

  // Outputs decoded from registered state
  always_comb begin
    byte_rdy_o  = rx_state;
    mem_req_o   = (state_q == ST_WR);
    mem_be_o    = (state_q == ST_WR) ? 4'hF : 4'h0;
    mem_addr_o  = addr_q;
    mem_wdata_o = wdata_q;
    busy_o      = rx_state || (state_q == ST_WR);
    done_o      = (state_q == ST_DONE);
    err_o       = (state_q == ST_ERR);
    err_code_o  = err_q;
    core_rst_o  = (state_q != ST_DONE);
    words_o     = words_q;
  end

endmodule

// File: tb/tb_tcm_boot_loader.sv
module tb_tcm_boot_loader;

  localparam int ADDR_W = 14;
  localparam int BASE   = 0;
  localparam int TMO    = 50;
  localparam longint LIM = (64'd1 << ADDR_W) - BASE;

  logic              clk = 1'b0;
  logic              rst_i, start_i, byte_vld_i, mem_gnt_i;
  logic [7:0]        byte_i;
  logic              byte_rdy_o, mem_req_o, busy_o, done_o, err_o, core_rst_o;
  logic [ADDR_W-1:0] mem_addr_o;
  logic [31:0]       mem_wdata_o;
  logic [3:0]        mem_be_o;
  logic [1:0]        err_code_o;
  logic [ADDR_W:0]   words_o;

  always #5 clk = ~clk;

  tcm_boot_loader #(
    .ADDR_W(ADDR_W), .BASE_ADDR(BASE), .TIMEOUT_CYC(TMO), .TO_W(20)
  ) dut (
    .clk_i(clk), .rst_i(rst_i), .start_i(start_i),
    .byte_vld_i(byte_vld_i), .byte_i(byte_i), .byte_rdy_o(byte_rdy_o),
    .mem_req_o(mem_req_o), .mem_addr_o(mem_addr_o), .mem_wdata_o(mem_wdata_o),
    .mem_be_o(mem_be_o), .mem_gnt_i(mem_gnt_i),
    .busy_o(busy_o), .done_o(done_o), .err_o(err_o), .err_code_o(err_code_o),
    .core_rst_o(core_rst_o), .words_o(words_o)
  );

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
  endtask

  // Grant model and write capture. Decided on the falling edge, so what is
  // recorded here is exactly what completes on the following rising edge.
  int          gnt_mode  = 0;   // 0 tied high, 1 fixed delay, 2 random delay
  int          gnt_delay = 0;
  int          stall_cnt = 0;
  bit          prev_stall = 0;
  logic [31:0] prev_addr, prev_data;
  logic [31:0] got_addr[$];
  logic [31:0] got_data[$];

  always @(negedge clk) begin
    if (mem_req_o) begin
      check("be", 32'(mem_be_o), 32'hF);
      check("rdy_in_wr", 32'(byte_rdy_o), 32'd0);
      if (prev_stall) begin
        check("addr_stable", 32'(mem_addr_o), prev_addr);
        check("data_stable", mem_wdata_o, prev_data);
      end
      if (gnt_mode == 0 || stall_cnt >= gnt_delay) begin
        mem_gnt_i = 1'b1;
        got_addr.push_back(32'(mem_addr_o));
        got_data.push_back(mem_wdata_o);
        stall_cnt  = 0;
        prev_stall = 0;
        if (gnt_mode == 2) gnt_delay = $urandom_range(0, 6);
      end else begin
        mem_gnt_i  = 1'b0;
        stall_cnt++;
        prev_stall = 1;
        prev_addr  = 32'(mem_addr_o);
        prev_data  = mem_wdata_o;
      end
    end else begin
      mem_gnt_i  = (gnt_mode == 0);
      stall_cnt  = 0;
      prev_stall = 0;
    end
  end

  logic [31:0] tx_words[$];

  task automatic check_reset_outputs(input string tag);
    check({tag, "_rdy"},   32'(byte_rdy_o), 0);
    check({tag, "_req"},   32'(mem_req_o), 0);
    check({tag, "_addr"},  32'(mem_addr_o), BASE);
    check({tag, "_wdata"}, mem_wdata_o, 0);
    check({tag, "_be"},    32'(mem_be_o), 0);
    check({tag, "_busy"},  32'(busy_o), 0);
    check({tag, "_done"},  32'(done_o), 0);
    check({tag, "_err"},   32'(err_o), 0);
    check({tag, "_code"},  32'(err_code_o), 0);
    check({tag, "_crst"},  32'(core_rst_o), 1);
    check({tag, "_words"}, 32'(words_o), 0);
  endtask

  // Called and returns on a falling edge.
  task automatic send_byte(input logic [7:0] b);
    int n = 0;
    byte_i     = b;
    byte_vld_i = 1'b1;
    while (!byte_rdy_o && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (n >= 200) check("rdy_wait_expired", 0, 1);
    @(posedge clk);
    @(negedge clk);
    byte_vld_i = 1'b0;
  endtask

  task automatic send_word(input logic [31:0] w, input int gap_max);
    for (int b = 0; b < 4; b++) begin
      repeat ($urandom_range(0, gap_max)) @(negedge clk);
      send_byte(w[8*b +: 8]);
    end
  endtask

  task automatic pulse_start();
    start_i = 1'b1;
    @(negedge clk);
    start_i = 1'b0;
  endtask

  // Sends one complete load from tx_words and checks the outcome against
  // the stream rules: length bound, sequential writes, additive checksum.
  task automatic run_load(input string tag, input logic [31:0] n_field,
                          input logic [31:0] csum, input int gap_max);
    logic [31:0] exp_sum = 0;
    bit ok;
    got_addr.delete();
    got_data.delete();
    pulse_start();
    check({tag, "_busy0"}, 32'(busy_o), 1);
    check({tag, "_crst0"}, 32'(core_rst_o), 1);
    check({tag, "_err0"},  32'(err_o), 0);
    check({tag, "_done0"}, 32'(done_o), 0);
    send_word(n_field, gap_max);
    if (longint'(n_field) > LIM) begin
      check({tag, "_err"},    32'(err_o), 1);
      check({tag, "_code"},   32'(err_code_o), 1);
      check({tag, "_nwr"},    got_addr.size(), 0);
      check({tag, "_crst"},   32'(core_rst_o), 1);
      check({tag, "_busy"},   32'(busy_o), 0);
      $display("load %s: N=0x%08h -> length error", tag, n_field);
      return;
    end
    for (int i = 0; i < int'(n_field); i++) begin
      send_word(tx_words[i], gap_max);
      exp_sum += tx_words[i];
    end
    send_word(csum, gap_max);
    ok = (csum == exp_sum);
    check({tag, "_done"},  32'(done_o), 32'(ok));
    check({tag, "_err"},   32'(err_o), 32'(!ok));
    check({tag, "_code"},  32'(err_code_o), ok ? 0 : 2);
    check({tag, "_crst"},  32'(core_rst_o), 32'(!ok));
    check({tag, "_busy"},  32'(busy_o), 0);
    check({tag, "_words"}, 32'(words_o), n_field);
    check({tag, "_nwr"},   got_addr.size(), n_field);
    for (int i = 0; i < int'(n_field) && i < got_addr.size(); i++) begin
      check($sformatf("%s_a%0d", tag, i), got_addr[i], BASE + i);
      check($sformatf("%s_d%0d", tag, i), got_data[i], tx_words[i]);
    end
    $display("load %s: N=%0d csum=0x%08h expected %s", tag, n_field, csum,
             ok ? "done" : "checksum error");
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int cnt;
    int n;
    logic [31:0] s;
    rst_i = 1'b1; start_i = 1'b0; byte_vld_i = 1'b0; byte_i = 8'h00;
    mem_gnt_i = 1'b1;
    repeat (3) @(negedge clk);
    check_reset_outputs("reset");
    rst_i = 1'b0;
    @(negedge clk);

    // Basic three-word load, grant tied high, then with 5-cycle stalls.
    tx_words = '{32'h00000013, 32'hDEADBEEF, 32'h12345678};
    s = 32'h00000013 + 32'hDEADBEEF + 32'h12345678;
    gnt_mode = 0;
    run_load("gnt_tied", 3, s, 0);
    gnt_mode = 1; gnt_delay = 5;
    run_load("gnt_dly5", 3, s, 2);

    // Wrong checksum.
    gnt_mode = 0;
    tx_words = '{32'd1, 32'd2};
    run_load("bad_csum", 2, 32'd4, 1);

    // Length one beyond the TCM, then exactly empty.
    run_load("len_ovf", 32'h00004001, 0, 0);
    tx_words.delete();
    run_load("len_zero", 0, 0, 1);

    // Stream stalls mid-load; error lands exactly TMO cycles later.
    pulse_start();
    send_word(32'd2, 0);
    send_byte(8'h11);
    send_byte(8'h22);
    cnt = 0;
    while (!err_o && cnt < 200) begin
      @(negedge clk);
      cnt++;
    end
    check("tmo_cycles", cnt, TMO);
    check("tmo_code", 32'(err_code_o), 3);
    check("tmo_crst", 32'(core_rst_o), 1);
    check("tmo_busy", 32'(busy_o), 0);
    $display("load timeout: error after %0d idle cycles", cnt);
    tx_words = '{32'hA5A5A5A5};
    run_load("after_tmo", 1, 32'hA5A5A5A5, 0);

    // Randomized loads with random grant latency and byte gaps.
    gnt_mode = 2; gnt_delay = 3;
    for (int t = 0; t < 6; t++) begin
      n = $urandom_range(1, 8);
      tx_words.delete();
      s = 0;
      for (int i = 0; i < n; i++) begin
        tx_words.push_back($urandom);
        s += tx_words[i];
      end
      if ($urandom_range(0, 1) == 1) s += 32'($urandom_range(1, 255));
      run_load($sformatf("rnd%0d", t), n, s, 3);
    end

    // Reset while the second of four words waits for its grant.
    gnt_mode = 0;
    tx_words.delete();
    for (int i = 0; i < 4; i++) tx_words.push_back($urandom);
    got_addr.delete();
    got_data.delete();
    pulse_start();
    send_word(32'd4, 0);
    send_word(tx_words[0], 0);
    cnt = 0;
    while (words_o != 1 && cnt < 50) begin
      @(negedge clk);
      cnt++;
    end
    gnt_mode = 1; gnt_delay = 1000;
    send_word(tx_words[1], 0);
    repeat (3) @(negedge clk);
    check("rst_pre_req", 32'(mem_req_o), 1);
    check("rst_pre_addr", 32'(mem_addr_o), BASE + 1);
    rst_i = 1'b1;
    @(negedge clk);
    check_reset_outputs("midrst");
    rst_i = 1'b0;
    repeat (10) @(negedge clk);
    check("midrst_req", 32'(mem_req_o), 0);
    check("midrst_nwr", got_addr.size(), 1);
    $display("load midrst: reset during second write, %0d write(s) issued", got_addr.size());
    gnt_mode = 0;
    s = tx_words[0] + tx_words[1] + tx_words[2] + tx_words[3];
    run_load("after_rst", 4, s, 1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
